// File: rtl/print_sink.sv
// print_sink: queues {a,b} pairs from the CPU's PRINT op and renders each pair
// as an ASCII line "a, b\r\n" on a valid/ready byte stream for the UART.
// Optional build macro PRINT_HEX_EN: two uppercase hex digits per value
// instead of decimal without leading zeros.
module print_sink #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          print_valid,
    input  logic [7:0]    print_a,
    input  logic [7:0]    print_b,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, CONV_A, SEND_A, CONV_B, SEND_B} state_t;
    state_t state, state_nxt;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, push, pop, xfer, last_byte, conv_done, conv_step, next_value;
    logic [7:0]    work;     // value being converted; holds the ones digit afterwards
    logic [7:0]    b_reg;
    logic [3:0]    dig_h, dig_t, dig_o;
    logic [1:0]    ndig;
    logic [2:0]    idx;      // byte position within the current half-line

    // Map a digit value 0..15 onto '0'-'9' / 'A'-'F'.
    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d < 4'd10) return 8'h30 + {4'h0, d};
        else           return 8'h37 + {4'h0, d};
    endfunction

    // Byte at position i of a half-line: n digits (most significant first),
    // then the two trailing characters s0 and s1.
    function automatic logic [7:0] line_char(
        input logic [2:0] i, input logic [1:0] n,
        input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
        input logic [7:0] s0, input logic [7:0] s1);
        logic [2:0] nn;
        logic [7:0] c;
        nn = {1'b0, n};
        if (i < nn) begin
            case (nn - i)
                3'd3:    c = to_ascii(h);
                3'd2:    c = to_ascii(t);
                default: c = to_ascii(o);
            endcase
        end else if (i == nn) begin
            c = s0;
        end else begin
            c = s1;
        end
        return c;
    endfunction

    assign full       = (fifo_count == FULL_CNT);
    assign push       = print_valid && !full;
    assign pop        = (state == IDLE) && (fifo_count != '0);
    assign xfer       = tx_valid && tx_ready;
    assign last_byte  = (idx == ({1'b0, ndig} + 3'd1));
    assign conv_step  = ((state == CONV_A) || (state == CONV_B)) && !conv_done;
    assign next_value = (state == SEND_A) && xfer && last_byte;

`ifdef PRINT_HEX_EN
    assign dig_h     = 4'd0;
    assign dig_t     = work[7:4];
    assign dig_o     = work[3:0];
    assign ndig      = 2'd2;
    assign conv_done = 1'b1;
`else
    logic [3:0] hund_cnt, tens_cnt;

    assign dig_h     = hund_cnt;
    assign dig_t     = tens_cnt;
    assign dig_o     = work[3:0];
    assign ndig      = (hund_cnt != 4'd0) ? 2'd3 : ((tens_cnt != 4'd0) ? 2'd2 : 2'd1);
    assign conv_done = (work < 8'd10);

    // Count subtractions of 100 first, then of 10, one per cycle.
    always_ff @(posedge clock) begin
        if (pop || next_value) begin
            hund_cnt <= 4'd0;
            tens_cnt <= 4'd0;
        end else if (conv_step) begin
            if (work >= 8'd100) hund_cnt <= hund_cnt + 4'd1;
            else                tens_cnt <= tens_cnt + 4'd1;
        end
    end
`endif

    // FIFO storage write; the full check happens before any same-cycle pop.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {print_a, print_b};
    end

    // Working value: load a on pop, reduce during decimal conversion, then load b.
    always_ff @(posedge clock) begin
        if (pop) begin
            work  <= mem[rd_ptr][15:8];
            b_reg <= mem[rd_ptr][7:0];
        end else if (next_value) begin
            work <= b_reg;
        end else if (conv_step) begin
            work <= work - ((work >= 8'd100) ? 8'd100 : 8'd10);
        end
    end

    // Control: pointers, occupancy, sticky overflow and byte index.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            idx        <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (print_valid && full) overflow <= 1'b1;
            if (xfer) idx <= last_byte ? 3'd0 : idx + 3'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state and byte-stream outputs.
    always_comb begin
        state_nxt = state;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (fifo_count != '0) state_nxt = CONV_A;
            end
            CONV_A: if (conv_done) state_nxt = SEND_A;
            SEND_A: begin
                tx_valid = 1'b1;
                tx_data  = line_char(idx, ndig, dig_h, dig_t, dig_o, 8'h2C, 8'h20);
                if (tx_ready && last_byte) state_nxt = CONV_B;
            end
            CONV_B: if (conv_done) state_nxt = SEND_B;
            SEND_B: begin
                tx_valid = 1'b1;
                tx_data  = line_char(idx, ndig, dig_h, dig_t, dig_o, 8'h0D, 8'h0A);
                if (tx_ready && last_byte) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_print_sink.sv
// Bench for print_sink: a string-formatting reference model feeds an expected
// byte queue; a monitor compares every transferred byte and the hold rule,
// and directed tests pin the model with hand-computed literal lines.
module tb_print_sink;
    logic       clock, reset, print_valid, tx_ready;
    logic [7:0] print_a, print_b, tx_data;
    logic       tx_valid, busy, overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       hold_pending = 1'b0;
    logic [7:0] hold_data = 8'h00;

`ifdef PRINT_HEX_EN
    localparam int LAT_MAX = 4;
`else
    localparam int LAT_MAX = 14;
`endif

    print_sink #(.DEPTH(4), .CW(3)) dut (
        .clock(clock), .reset(reset), .print_valid(print_valid),
        .print_a(print_a), .print_b(print_b), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    // Reference model: the text line for a pair, built with string formatting.
    task automatic model_line(input logic [7:0] a, input logic [7:0] b);
        string s;
`ifdef PRINT_HEX_EN
        s = $sformatf("%h, %h", a, b);
        s = s.toupper();
`else
        s = $sformatf("%0d, %0d", a, b);
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Monitor: every transferred byte against the model; held bytes stay put.
    always @(negedge clock) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, hold_data});
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_byte: got 0x%0h, required no byte", tx_data);
                end else begin
                    check("stream_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
                got_q.push_back(tx_data);
            end
            hold_pending = tx_valid && !tx_ready;
            hold_data    = tx_data;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input bit accepted);
        print_a     = a;
        print_b     = b;
        print_valid = 1'b1;
        if (accepted) model_line(a, b);
        @(posedge clock); #1;
        print_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!tx_valid && lat < 60) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 400) begin
            @(posedge clock); #1;
            n++;
            done = (exp_q.size() == 0) && (busy == 1'b0) && (fifo_count == 3'd0);
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_bytes(input string name, input int base, input logic [63:0] lit, input int n);
        logic [7:0] e, g;
        for (int i = 0; i < n; i++) begin
            e = lit[8*(n-1-i) +: 8];
            g = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
            check($sformatf("%s[%0d]", name, i), {24'd0, g}, {24'd0, e});
        end
    endtask

    initial begin
        int base, lat, n;
        reset = 1'b1; print_valid = 1'b0; print_a = 8'h00; print_b = 8'h00; tx_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // Pair (12,3) with the transmitter always ready.
        base = got_q.size();
        push(8'd12, 8'd3, 1'b1);
        wait_valid(lat);
        check("t1_latency_ok", {31'd0, (lat <= LAT_MAX)}, 32'd1);
        wait_done("t1");
`ifdef PRINT_HEX_EN
        check_bytes("t1_hex", base, 64'h30432C2030330D0A, 8);
`else
        check_bytes("t1_line", base, 64'h0031322C20330D0A, 7);
`endif
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_overflow", {31'd0, overflow}, 32'd0);

        // Zero and the largest value.
        base = got_q.size();
        push(8'd0, 8'd255, 1'b1);
        wait_done("t2");
`ifdef PRINT_HEX_EN
        check_bytes("t2_hex", base, 64'h30302C2046460D0A, 8);
`else
        check_bytes("t2_line", base, 64'h302C203235350D0A, 8);
`endif

        // Back-pressure: first byte must be held for 20 cycles.
        base = got_q.size();
        tx_ready = 1'b0;
        push(8'd100, 8'd9, 1'b1);
        wait_valid(lat);
        check("t3_valid_seen", {31'd0, tx_valid}, 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            check("t3_stall_valid", {31'd0, tx_valid}, 32'd1);
`ifdef PRINT_HEX_EN
            check("t3_stall_data", {24'd0, tx_data}, 32'h36);
`else
            check("t3_stall_data", {24'd0, tx_data}, 32'h31);
`endif
        end
        tx_ready = 1'b1;
        wait_done("t3");
`ifdef PRINT_HEX_EN
        check_bytes("t3_hex", base, 64'h36342C2030390D0A, 8);
`else
        check_bytes("t3_line", base, 64'h3130302C20390D0A, 8);
`endif

        // Overflow: six pushes into a stalled sink, the sixth is dropped.
        base = got_q.size();
        tx_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push(8'(k), 8'(k), k <= 5);
        check("t4_fifo_count", {29'd0, fifo_count}, 32'd4);
        check("t4_overflow", {31'd0, overflow}, 32'd1);
        tx_ready = 1'b1;
        wait_done("t4");
`ifdef PRINT_HEX_EN
        check("t4_byte_total", got_q.size() - base, 32'd40);
`else
        check("t4_byte_total", got_q.size() - base, 32'd30);
`endif
        check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

        // Reset while the second value of a line is being sent.
        base = got_q.size();
        push(8'd123, 8'd45, 1'b1);
        n = 0;
        while (got_q.size() < base + 6 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("t5_reached_send_b", {31'd0, (got_q.size() >= base + 6)}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        check("t5_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t5_tx_data", {24'd0, tx_data}, 32'h00);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_fifo_count", {29'd0, fifo_count}, 32'd0);
        check("t5_overflow", {31'd0, overflow}, 32'd0);
        repeat (10) @(posedge clock);
        #1;
        check("t5_no_resume", got_q.size() - base, 32'd6);
        base = got_q.size();
        push(8'd8, 8'd8, 1'b1);
        wait_done("t5");
`ifdef PRINT_HEX_EN
        check_bytes("t5_hex", base, 64'h30382C2030380D0A, 8);
`else
        check_bytes("t5_line", base, 64'h0000382C20380D0A, 6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/print_sink.md
Name: print_sink

Overview:
- Downstream consumer of the I8 CPU's PRINT system op.
- Each PRINT event carries two 8-bit values: a = second-on-stack (S1) and b = top-of-stack (S0).
- The block queues these pairs and renders each one as an ASCII text line.
- Output is a byte stream with a valid/ready handshake, intended to feed the board's UART transmitter. This gives PRINT real hardware output instead of simulation-only display.

Parameters:
- DEPTH, 4, FIFO entries of {a,b} pairs; power of 2, minimum 2.
- CW, 3, width of fifo_count; must equal log2(DEPTH)+1.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- print_valid  input  1  one-cycle pulse per PRINT op.
- print_a  input  8  S1 value, sampled when print_valid=1.
- print_b  input  8  S0 value, sampled when print_valid=1.
- tx_data  output  8  ASCII byte to the transmitter.
- tx_valid  output  1  tx_data holds a byte.
- tx_ready  input  1  transmitter accepts the byte.
- busy  output  1  a line is being formatted or sent.
- fifo_count  output  CW  number of queued pairs.
- overflow  output  1  sticky; set when a pair is dropped.

Behaviour:
- Reset is synchronous. On the reset edge: FIFO empty, FSM goes to IDLE. Outputs take these values after that edge: tx_valid=0, tx_data=0x00, busy=0, fifo_count=0, overflow=0.
- Reset mid-line aborts the line: no further bytes are sent and the partial line is not resumed.
- Push rule:
  - print_valid=1 and FIFO not full: the pair is written; fifo_count increments on the next edge.
  - If a pop occurs in the same cycle, the push still happens and fifo_count is unchanged.
- Full rule:
  - Full is evaluated before any same-cycle pop.
  - print_valid=1 while full drops the pair and sets overflow.
  - overflow clears only on reset.
- Unsigned unit: all values are treated as unsigned 0..255.
- Line format (decimal): DEC(a), ',' (0x2C), ' ' (0x20), DEC(b), CR (0x0D), LF (0x0A).
  - DEC omits leading zeros.
  - Zero is rendered as the single character '0'.
  - Example: 7 -> "7"; 40 -> "40"; 255 -> "255".
- FSM states:
  - IDLE: if fifo_count != 0, pop the head into a_reg/b_reg, set busy=1, go to CONV_A.
  - CONV_A: repeated subtraction, one subtract per cycle: first 100s, then 10s. Produces hundreds, tens and ones digits; at most 11 cycles. Then go to SEND_A.
  - SEND_A: emit DEC(a) digits, then ',', then ' '. Go to CONV_B.
  - CONV_B: same conversion as CONV_A, applied to b_reg.
  - SEND_B: emit DEC(b) digits, CR, LF. Go to IDLE with busy=0.
  - A new pop may occur in the cycle immediately after LF is accepted.
- Handshake:
  - A byte transfers on a cycle where tx_valid and tx_ready are both 1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays 1.
  - tx_valid never drops without a transfer, except on reset.
  - Back-to-back bytes within a SEND state are allowed: one byte per cycle when tx_ready is held at 1.
- Latency: with the FIFO empty, FSM in IDLE and tx_ready=1, the first byte has tx_valid=1 no later than 14 cycles after the print_valid edge.
- Ordering: lines are emitted strictly in push order. No byte is duplicated or reordered.
- Pointers: wrap modulo DEPTH.

Optional Feature:
- Macro: PRINT_HEX_EN.
- Defined:
  - Each value is rendered as exactly two uppercase hex digits ('0'-'9', 'A'-'F'), with no leading-zero suppression.
  - CONV_A and CONV_B take one cycle each.
  - The latency bound becomes 4 cycles.
  - Separators, CR and LF are unchanged.
- Undefined: decimal format as specified above.

Test Plan:
- push (a=12, b=3), tx_ready=1 -> bytes 31 32 2C 20 33 0D 0A. busy returns to 0 after LF. overflow=0.
- push (0, 255) -> bytes 30 2C 20 32 35 35 0D 0A.
- push (100, 9), tx_ready=0 for 20 cycles after the first tx_valid -> tx_data stays 0x31 with tx_valid=1 throughout. After release, the full line "100, 9\r\n" is emitted with no loss.
- DEPTH=4, tx_ready=0, six consecutive print_valid pulses with pairs (1,1)..(6,6) -> fifo_count reaches 4 and overflow=1. Releasing tx_ready yields exactly five lines, "1, 1" through "5, 5", in order.
- reset asserted for one cycle during SEND_B -> tx_valid=0, busy=0, fifo_count=0 after that edge. A following push (8,8) emits a clean "8, 8\r\n".
- With PRINT_HEX_EN: push (12, 3) -> bytes 30 43 2C 20 30 33 0D 0A, and the first byte arrives within 4 cycles.
